// File: rtl/mem_wb_writeback_if.sv
// rtl/mem_wb_writeback_if.sv - MEM/WB stage bus: MEM-side inputs and register-file write port (fwd outputs under WB_FWD_EN)
interface mem_wb_writeback_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush;
    logic             mem_valid;
    logic             mem_reg_write;
    logic             mem_mem_to_reg;
    logic [3:0]       mem_rd;
    logic [15:0]      mem_alu_result;
    logic [15:0]      mem_read_data;
    logic             mem_halt;
    logic             wb_reg_write;
    logic [3:0]       wb_rd;
    logic [15:0]      wb_data;
    logic             halted;
    logic [CNT_W-1:0] retired;
`ifdef WB_FWD_EN
    logic             fwd_valid;
    logic [3:0]       fwd_rd;
    logic [15:0]      fwd_data;

    modport master (
        output stall, flush, mem_valid, mem_reg_write, mem_mem_to_reg, mem_rd,
               mem_alu_result, mem_read_data, mem_halt,
        input  wb_reg_write, wb_rd, wb_data, halted, retired,
               fwd_valid, fwd_rd, fwd_data
    );
    modport slave (
        input  stall, flush, mem_valid, mem_reg_write, mem_mem_to_reg, mem_rd,
               mem_alu_result, mem_read_data, mem_halt,
        output wb_reg_write, wb_rd, wb_data, halted, retired,
               fwd_valid, fwd_rd, fwd_data
    );
`else
    modport master (
        output stall, flush, mem_valid, mem_reg_write, mem_mem_to_reg, mem_rd,
               mem_alu_result, mem_read_data, mem_halt,
        input  wb_reg_write, wb_rd, wb_data, halted, retired
    );
    modport slave (
        input  stall, flush, mem_valid, mem_reg_write, mem_mem_to_reg, mem_rd,
               mem_alu_result, mem_read_data, mem_halt,
        output wb_reg_write, wb_rd, wb_data, halted, retired
    );
`endif
endinterface

// File: rtl/mem_wb_writeback.sv
// rtl/mem_wb_writeback.sv - MEM/WB pipeline register, writeback select, halt drain and retire counter (optional WB_FWD_EN forwarding)
module mem_wb_writeback #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    mem_wb_writeback_if.slave   bus
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q;

    logic        v_q, rw_q, m2r_q, halt_q, fresh_q;
    logic [3:0]  rd_q;
    logic [15:0] alu_q, rdat_q;
    logic        retire_evt, wr_en;

    // fresh_q marks the first cycle an instruction sits in WB so a stalled one counts once
    assign retire_evt = v_q & fresh_q & (state_q == RUN);
    assign wr_en      = v_q & rw_q & ~halt_q & (rd_q != 4'd0) & (state_q == RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (retire_evt && halt_q) begin
                    state_d = DRAIN;
                    cnt_d   = 4'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (cnt_q == 4'd0) state_d = HALTED;
                else               cnt_d   = cnt_q - 4'd1;
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Once HALT has retired, nothing younger may enter WB
    always_ff @(posedge clk) begin
        if (rst || state_q != RUN || bus.flush) begin
            v_q     <= 1'b0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            halt_q  <= 1'b0;
            rd_q    <= 4'd0;
            alu_q   <= 16'd0;
            rdat_q  <= 16'd0;
            fresh_q <= 1'b1;
        end else if (bus.stall) begin
            fresh_q <= 1'b0;
        end else begin
            v_q     <= bus.mem_valid;
            rw_q    <= bus.mem_reg_write;
            m2r_q   <= bus.mem_mem_to_reg;
            halt_q  <= bus.mem_halt;
            rd_q    <= bus.mem_rd;
            alu_q   <= bus.mem_alu_result;
            rdat_q  <= bus.mem_read_data;
            fresh_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)             count_q <= '0;
        else if (retire_evt) count_q <= count_q + 1'b1;
    end

    assign bus.wb_reg_write = wr_en;
    assign bus.wb_rd        = rd_q;
    assign bus.wb_data      = m2r_q ? rdat_q : alu_q;
    // The instruction in its retiring cycle is already included in the visible count
    assign bus.retired      = count_q + CNT_W'(retire_evt);
    assign bus.halted       = (state_q == HALTED) || (state_q == DRAIN && cnt_q == 4'd0);

`ifdef WB_FWD_EN
    logic        fwd_valid_q;
    logic [3:0]  fwd_rd_q;
    logic [15:0] fwd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_q <= 1'b0;
            fwd_rd_q    <= 4'd0;
            fwd_data_q  <= 16'd0;
        end else begin
            fwd_valid_q <= wr_en & (state_q == RUN);
            fwd_rd_q    <= rd_q;
            fwd_data_q  <= m2r_q ? rdat_q : alu_q;
        end
    end

    assign bus.fwd_valid = fwd_valid_q;
    assign bus.fwd_rd    = fwd_rd_q;
    assign bus.fwd_data  = fwd_data_q;
`endif
endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb/tb_mem_wb_writeback.sv - randomized and directed bench for mem_wb_writeback against a timestamp-based reference model
module tb_mem_wb_writeback;
    localparam int D  = 2;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_wb_writeback_if #(.CNT_W(CW)) bus();

    mem_wb_writeback #(.DRAIN_CYCLES(D), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic        v, rw, m2r, h, fresh;
        logic [3:0]  rd;
        logic [15:0] alu, rdat;
    } slot_t;

    slot_t       ms;
    int          m_count;
    bit          halt_seen;
    int          halt_t;
    int          cyc;
    bit          pf_v;
    logic [3:0]  pf_rd;
    logic [15:0] pf_data;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit locked();
        return halt_seen && (cyc > halt_t);
    endfunction
    function automatic bit exp_wr();
        return ms.v && ms.rw && !ms.h && (ms.rd != 4'd0) && !locked();
    endfunction
    function automatic bit exp_evt();
        return ms.v && ms.fresh && !locked();
    endfunction
    function automatic logic [15:0] exp_data();
        return ms.m2r ? ms.rdat : ms.alu;
    endfunction
    function automatic bit exp_halted();
        return halt_seen && (cyc >= halt_t + D);
    endfunction

    task automatic check_all();
        check("wb_reg_write", bus.wb_reg_write, exp_wr());
        check("wb_rd", bus.wb_rd, ms.rd);
        check("wb_data", bus.wb_data, exp_data());
        check("halted", bus.halted, exp_halted());
        check("retired", bus.retired, (m_count + int'(exp_evt())) % (1 << CW));
`ifdef WB_FWD_EN
        check("fwd_valid", bus.fwd_valid, pf_v);
        if (pf_v) begin
            check("fwd_rd", bus.fwd_rd, pf_rd);
            check("fwd_data", bus.fwd_data, pf_data);
        end
`endif
    endtask

    task automatic do_cycle(input bit r, input bit s, input bit f, input bit v, input bit rw,
                            input bit m2r, input bit h, input logic [3:0] rd,
                            input logic [15:0] alu, input logic [15:0] rdat);
        bit lk;
        rst = r;
        bus.stall = s;          bus.flush = f;
        bus.mem_valid = v;      bus.mem_reg_write = rw;
        bus.mem_mem_to_reg = m2r; bus.mem_halt = h;
        bus.mem_rd = rd;        bus.mem_alu_result = alu;
        bus.mem_read_data = rdat;
        @(posedge clk);
        if (r) begin
            ms = '0;
            ms.fresh = 1'b1;
            m_count = 0;
            halt_seen = 0;
            pf_v = 0;
        end else begin
            lk = locked();
            pf_v = exp_wr();
            pf_rd = ms.rd;
            pf_data = exp_data();
            if (exp_evt()) begin
                m_count++;
                if (ms.h) begin
                    halt_seen = 1;
                    halt_t = cyc;
                end
            end
            if (lk || f) begin
                ms = '0;
                ms.fresh = 1'b1;
            end else if (s) begin
                ms.fresh = 1'b0;
            end else begin
                ms = '{v: v, rw: rw, m2r: m2r, h: h, fresh: 1'b1, rd: rd, alu: alu, rdat: rdat};
            end
        end
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic op(input bit v, input bit rw, input bit m2r, input bit h,
                      input logic [3:0] rd, input logic [15:0] alu, input logic [15:0] rdat);
        do_cycle(0, 0, 0, v, rw, m2r, h, rd, alu, rdat);
    endtask

    task automatic do_reset();
        do_cycle(1, 0, 0, 0, 0, 0, 0, 4'd0, 16'd0, 16'd0);
    endtask

    initial begin
        int halted_for;
        bit r, s, f, v, rw, m2r, h;
        cyc = 0;
        halt_t = 0;
        halt_seen = 0;
        m_count = 0;
        ms = '0;
        pf_v = 0;
        pf_rd = 4'd0;
        pf_data = 16'd0;
        @(negedge clk);

        do_reset();
        do_reset();
        check("rst_wreg", bus.wb_reg_write, 0);
        check("rst_rd", bus.wb_rd, 0);
        check("rst_data", bus.wb_data, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_retired", bus.retired, 0);

        op(1, 1, 0, 0, 4'd3, 16'h1234, 16'h0000);
        check("alu_wreg", bus.wb_reg_write, 1);
        check("alu_rd", bus.wb_rd, 3);
        check("alu_data", bus.wb_data, 16'h1234);
        check("alu_retired", bus.retired, 1);

        op(1, 1, 1, 0, 4'd5, 16'h0040, 16'hBEEF);
        check("load_data", bus.wb_data, 16'hBEEF);
        check("load_wreg", bus.wb_reg_write, 1);

        op(1, 1, 0, 0, 4'd0, 16'h5555, 16'h0000);
        check("r0_wreg", bus.wb_reg_write, 0);
        check("r0_retired", bus.retired, 3);

        op(1, 1, 0, 0, 4'd7, 16'h0777, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            do_cycle(0, 1, 0, 1, 1, 0, 0, 4'd2, 16'h0222, 16'h0000);
            check("stall_rd", bus.wb_rd, 7);
            check("stall_retired", bus.retired, 4);
        end
        do_cycle(0, 1, 1, 1, 1, 0, 0, 4'd2, 16'h0222, 16'h0000);
        check("flush_wreg", bus.wb_reg_write, 0);
        check("flush_retired", bus.retired, 4);

        do_reset();
        op(1, 1, 0, 1, 4'd4, 16'h0444, 16'h0000);
        check("halt_t_wreg", bus.wb_reg_write, 0);
        check("halt_t_retired", bus.retired, 1);
        check("halt_t_halted", bus.halted, 0);
        op(1, 1, 0, 0, 4'd4, 16'h0444, 16'h0000);
        check("halt_t1_wreg", bus.wb_reg_write, 0);
        check("halt_t1_halted", bus.halted, 0);
        op(1, 1, 0, 0, 4'd4, 16'h0444, 16'h0000);
        check("halt_t2_halted", bus.halted, 1);
        for (int i = 0; i < 10; i++) begin
            op(1, 1, 0, 0, 4'd4, 16'h0444, 16'h0000);
            check("halt_hold", bus.halted, 1);
            check("halt_hold_wreg", bus.wb_reg_write, 0);
            check("halt_hold_retired", bus.retired, 1);
        end
        do_reset();
        check("halt_rst_halted", bus.halted, 0);
        check("halt_rst_retired", bus.retired, 0);

        for (int i = 0; i < 17; i++)
            op(1, 1, 0, 0, 4'(i), 16'(i), 16'h0000);
        check("wrap_retired", bus.retired, 1);

`ifdef WB_FWD_EN
        do_reset();
        op(1, 1, 0, 0, 4'd9, 16'h00AA, 16'h0000);
        op(0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000);
        check("fwd_v1", bus.fwd_valid, 1);
        check("fwd_rd1", bus.fwd_rd, 9);
        check("fwd_data1", bus.fwd_data, 16'h00AA);
        op(0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000);
        check("fwd_v2", bus.fwd_valid, 0);
`endif

        do_reset();
        halted_for = 0;
        for (int n = 0; n < 2000; n++) begin
            r   = ($urandom_range(0, 99) < 2) || (halted_for >= 12);
            s   = $urandom_range(0, 99) < 25;
            f   = $urandom_range(0, 99) < 10;
            v   = $urandom_range(0, 99) < 80;
            rw  = $urandom_range(0, 99) < 75;
            m2r = $urandom_range(0, 1) == 1;
            h   = $urandom_range(0, 99) < 4;
            do_cycle(r, s, f, v, rw, m2r, h, 4'($urandom_range(0, 15)),
                     16'($urandom), 16'($urandom));
            halted_for = exp_halted() ? halted_for + 1 : 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
